pc_fetch_sequencer: RTL

//  Sequences the program counter and the instruction-memory fetch handshake for the RISC-V core.

---
 rtl/pc_fetch_if.sv | 29 ++
 rtl/pc_fetch_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bus of the PC sequencer: redirect strobes in, instruction-memory handshake and
// presented PC out. The master modport is the sequencer; the slave modport is its environment.
interface pc_fetch_if;
   localparam int unsigned XLEN = 32;

   logic            is_stall;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            jump_valid;
   logic [XLEN-1:0] jump_target;
   logic            trap_valid;
   logic            pc_valid;
   logic [XLEN-1:0] pc;
   logic            flush;
   logic            misalign;

   modport master (
      input  is_stall, imem_ack, branch_taken, branch_target, jump_valid, jump_target, trap_valid,
      output imem_req, imem_addr, pc_valid, pc, flush, misalign
   );

   modport slave (
      output is_stall, imem_ack, branch_taken, branch_target, jump_valid, jump_target, trap_valid,
      input  imem_req, imem_addr, pc_valid, pc, flush, misalign
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: boot, fetch handshake with instruction memory, stall hold and
// prioritised trap/jump/branch redirects with flush and misalignment reporting.
module pc_fetch_sequencer #(
   parameter logic [31:0] START_ADDR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC   = 32'h0000_0004,
   parameter int unsigned INST_BYTES = 4
) (
   input logic        clock,
   input logic        reset,
   pc_fetch_if.master bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned PRI_W = 2;
   localparam logic [PRI_W-1:0] PRI_BRANCH = 2'd0;
   localparam logic [PRI_W-1:0] PRI_JUMP   = 2'd1;
   localparam logic [PRI_W-1:0] PRI_TRAP   = 2'd2;

   typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

   state_t            state_q, state_n;
   logic              imem_req_q, imem_req_n;
   logic [XLEN-1:0]   imem_addr_q, imem_addr_n;
   logic [XLEN-1:0]   pc_q, pc_n;
   logic              pc_valid_q, pc_valid_n;
   logic              flush_q, flush_n;
   logic              misalign_q, misalign_n;
   logic              pend_q, pend_n;
   logic [XLEN-1:0]   pend_tgt_q, pend_tgt_n;
   logic [PRI_W-1:0]  pend_pri_q, pend_pri_n;

   logic              red_valid_c, red_mis_c, red_accept_c, consumed_c;
   logic [PRI_W-1:0]  red_pri_c;
   logic [XLEN-1:0]   red_raw_c, red_tgt_c;

   // Redirect decode; a strobe is accepted only if it outranks any pending redirect
   always_comb begin
      red_valid_c = bus.trap_valid | bus.jump_valid | bus.branch_taken;
      red_pri_c   = PRI_BRANCH;
      red_raw_c   = bus.branch_target;
      if (bus.trap_valid) begin
         red_pri_c = PRI_TRAP;
         red_raw_c = TRAP_VEC;
      end else if (bus.jump_valid) begin
         red_pri_c = PRI_JUMP;
         red_raw_c = bus.jump_target;
      end
      red_mis_c    = red_valid_c && (red_raw_c[1:0] != 2'b00);
      red_tgt_c    = red_mis_c ? TRAP_VEC : red_raw_c;
      red_accept_c = red_valid_c && (state_q != BOOT) && (!pend_q || (red_pri_c > pend_pri_q));
      consumed_c   = pc_valid_q && !bus.is_stall;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n     = state_q;
      imem_addr_n = imem_addr_q;
      pc_n        = pc_q;
      pc_valid_n  = pc_valid_q;
      pend_n      = pend_q;
      pend_tgt_n  = pend_tgt_q;
      pend_pri_n  = pend_pri_q;
      flush_n     = red_accept_c;
      misalign_n  = red_accept_c && red_mis_c;

      unique case (state_q)
         BOOT: begin
            state_n = FETCH;
         end
         FETCH: begin
            if (bus.imem_ack) begin
               if (red_accept_c || pend_q) begin
                  pc_valid_n  = 1'b0;
                  imem_addr_n = red_accept_c ? red_tgt_c : pend_tgt_q;
               end else begin
                  pc_n        = imem_addr_q;
                  pc_valid_n  = 1'b1;
                  imem_addr_n = imem_addr_q + XLEN'(INST_BYTES);
               end
               pend_n  = 1'b0;
               state_n = bus.is_stall ? HOLD : FETCH;
            end else begin
               if (consumed_c) pc_valid_n = 1'b0;
               if (red_accept_c) begin
                  pend_n     = 1'b1;
                  pend_tgt_n = red_tgt_c;
                  pend_pri_n = red_pri_c;
                  pc_valid_n = 1'b0;
               end
            end
         end
         HOLD: begin
            if (consumed_c) pc_valid_n = 1'b0;
            // No request is outstanding here, so a redirect retargets the next fetch directly
            if (red_accept_c) begin
               imem_addr_n = red_tgt_c;
               pc_valid_n  = 1'b0;
            end
            if (!bus.is_stall) state_n = FETCH;
         end
         default: begin
            state_n = BOOT;
         end
      endcase

      imem_req_n = (state_n == FETCH);
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT;
         imem_req_q  <= 1'b0;
         imem_addr_q <= START_ADDR;
         pc_q        <= START_ADDR;
         pc_valid_q  <= 1'b0;
         flush_q     <= 1'b0;
         misalign_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
         pend_pri_q  <= PRI_BRANCH;
      end else begin
         state_q     <= state_n;
         imem_req_q  <= imem_req_n;
         imem_addr_q <= imem_addr_n;
         pc_q        <= pc_n;
         pc_valid_q  <= pc_valid_n;
         flush_q     <= flush_n;
         misalign_q  <= misalign_n;
         pend_q      <= pend_n;
         pend_tgt_q  <= pend_tgt_n;
         pend_pri_q  <= pend_pri_n;
      end
   end

   assign bus.imem_req  = imem_req_q;
   assign bus.imem_addr = imem_addr_q;
   assign bus.pc        = pc_q;
   assign bus.pc_valid  = pc_valid_q;
   assign bus.flush     = flush_q;
   assign bus.misalign  = misalign_q;
endmodule
